// File: rtl/hack_pkg.sv
// Shared field layout and decode helpers for the parametrised Hack core.
// The low 13 bits of a C-instruction keep the classic Hack layout at every DATA_W.
package hack_pkg;

    localparam int A_BIT   = 12;
    localparam int ALU_HI  = 11;
    localparam int ALU_LO  = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    // Bit positions inside the extracted dest / jump slices
    localparam int DEST_A = 2;
    localparam int DEST_D = 1;
    localparam int DEST_M = 0;
    localparam int J_LT   = 2;
    localparam int J_EQ   = 1;
    localparam int J_GT   = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } aluCtrl_t;

    typedef struct packed {
        logic       isC;
        logic       a;
        aluCtrl_t   alu;
        logic [2:0] dest;
        logic [2:0] jmp;
    } decoded_t;

    function automatic int opcodeBit(input int dataW);
        return dataW - 1;
    endfunction

    function automatic decoded_t decode(input logic opcode, input logic [A_BIT:0] low);
        decoded_t d;
        d.isC  = opcode;
        d.a    = low[A_BIT];
        d.alu  = aluCtrl_t'(low[ALU_HI:ALU_LO]);
        d.dest = low[DEST_HI:DEST_LO];
        d.jmp  = low[JUMP_HI:JUMP_LO];
        return d;
    endfunction

endpackage

// File: rtl/hack_cpu_stall_alu.sv
// Width-parametrised Hack ALU: zero/invert each operand, add or AND, optional
// output inversion, plus zero and negative flags.
module hack_alu_w
    import hack_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  aluCtrl_t          ctrl,
    output logic [DATA_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] xz, xn, yz, yn, res;

    assign xz  = ctrl.zx ? '0 : x;
    assign xn  = ctrl.nx ? ~xz : xz;
    assign yz  = ctrl.zy ? '0 : y;
    assign yn  = ctrl.ny ? ~yz : yz;
    assign res = ctrl.f ? (xn + yn) : (xn & yn);
    assign out = ctrl.no ? ~res : res;
    assign zr  = (out == '0);
    assign ng  = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_stall.sv
// Single-cycle Hack core with instruction-valid gating, a data-memory ready
// stall and a retired-instruction counter.
module hack_cpu_stall
    import hack_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instruction,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] inM,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired
);

    localparam int OPC = opcodeBit(DATA_W);

    logic [DATA_W-1:0] regA, regD, aluY, aluOut;
    logic [ADDR_W-1:0] pcQ;
    logic [CNT_W-1:0]  retQ;
    logic              zr, ng, usesM, commit, jump;
    decoded_t          dec;
    logic              unusedHiBits;

    assign dec          = decode(instruction[OPC], instruction[A_BIT:0]);
    assign unusedHiBits = ^instruction[OPC-1:A_BIT+1];

    assign aluY = dec.a ? inM : regA;

    hack_alu_w #(.DATA_W(DATA_W)) uAlu (
        .x   (regD),
        .y   (aluY),
        .ctrl(dec.alu),
        .out (aluOut),
        .zr  (zr),
        .ng  (ng)
    );

    // Any C-instruction touching memory (read via a=1 or write via dM) waits for mem_ready
    assign usesM  = dec.isC & (dec.a | dec.dest[DEST_M]);
    assign commit = instr_valid & (~usesM | mem_ready);
    assign jump   = dec.isC & ((dec.jmp[J_LT] & ng) |
                               (dec.jmp[J_EQ] & zr) |
                               (dec.jmp[J_GT] & ~ng & ~zr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regA <= '0;
            regD <= '0;
            pcQ  <= '0;
            retQ <= '0;
        end else if (commit) begin
            if (!dec.isC)
                regA <= {1'b0, instruction[OPC-1:0]};
            else if (dec.dest[DEST_A])
                regA <= aluOut;
            if (dec.isC && dec.dest[DEST_D])
                regD <= aluOut;
            // Jump target is the pre-commit A, even when the same instruction writes A
            pcQ  <= jump ? regA[ADDR_W-1:0] : pcQ + ADDR_W'(1);
            retQ <= retQ + CNT_W'(1);
        end
    end

    // Strobe is held through the stall; reset drops a pending write at once
    assign writeM   = reset & instr_valid & dec.isC & dec.dest[DEST_M];
    assign outM     = aluOut;
    assign addressM = regA[ADDR_W-1:0];
    assign pc       = pcQ;
    assign retired  = retQ;

endmodule

// File: doc/hack_cpu_stall.md
Name: hack_cpu_stall

Overview:
- Parametrised next-generation Hack CPU core: executes Hack A- and C-instructions, one per cycle, with data width and address width as parameters.
- Adds what the base CPU lacks: an instruction-valid input, a data-memory ready handshake that stalls the core, and a retired-instruction counter.
- Sits between instruction ROM and data RAM/MMIO in the computer top level; a drop-in for CPU when parameters are at defaults and instr_valid = mem_ready = 1.

Parameters:
- DATA_W, 16, data word and instruction width; MSB is the opcode bit; must be >= 16.
- ADDR_W, 15, width of addressM and pc; must be <= DATA_W-1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instruction  in  DATA_W  instruction word at pc
- instr_valid  in  1  instruction is valid this cycle
- inM  in  DATA_W  data read from RAM[addressM]
- mem_ready  in  1  data memory accepts the write, or inM is valid, this cycle
- outM  out  DATA_W  ALU result, the data to write
- writeM  out  1  write strobe for RAM[addressM]
- addressM  out  ADDR_W  A[ADDR_W-1:0]
- pc  out  ADDR_W  address of the next instruction
- retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset (reset=0, async):
  - A, D, pc and retired = 0; writeM = 0.
  - Outputs hold these values while reset is low.
  - Release is sampled at the next rising clk edge.
- Decode:
  - instruction[DATA_W-1]=0 is an A-instruction: A <= zero-extended instruction[DATA_W-2:0].
  - Otherwise it is a C-instruction. Fixed low fields: a=[12], zx nx zy ny f no=[11:6], dA dD dM=[5:3], jlt jeq jgt=[2:0].
  - Bits [DATA_W-2:13] of a C-instruction are ignored.
- ALU (combinational, DATA_W bits):
  - x = D; y = a ? inM : A.
  - zx zeroes x, nx inverts x, zy zeroes y, ny inverts y.
  - f selects x+y (mod 2^DATA_W) or x&y; no inverts the result.
  - zr = (out==0); ng = out[DATA_W-1].
- Memory use: usesM = C & (a | dM).
- Commit condition: commit = instr_valid & (~usesM | mem_ready).
- On commit (rising edge):
  - A <= dest value if A-instruction or dA; D <= out if dD.
  - jump = C & ((jlt&ng) | (jeq&zr) | (jgt&~ng&~zr)).
  - pc <= jump ? old A[ADDR_W-1:0] : pc+1, wrapping modulo 2^ADDR_W.
  - retired <= retired+1, wrapping.
- No commit: A, D, pc and retired hold. This is a stall.
- writeM = instr_valid & C & dM, combinational.
  - Stays asserted through stall cycles.
  - The memory performs the write in the cycle mem_ready=1, which is the commit cycle.
- Outputs:
  - outM is combinational from the ALU.
  - addressM always reflects the pre-commit A.
- Simultaneous dest A and M (AM=...):
  - The write goes to the old A address.
  - A updates after the edge.
- Jump with dA: the jump target is the old A; the new A value is visible next cycle.
- Latency: 1 cycle per instruction when unstalled. No pipelining and no branch penalty.
- Reset asserted mid-stall: the state clears immediately; the pending write is dropped.

Decomposition:
- Package hack_pkg holds:
  - the OPCODE bit index function;
  - field constants for A_BIT, the ALU control slice [11:6], the DEST slice [5:3] and the JUMP slice [2:0];
  - DEST_A/DEST_D/DEST_M and J_LT/J_EQ/J_GT bit positions.
- One sub-module, hack_alu_w: parametrised DATA_W combinational ALU producing out, zr and ng.
- The top holds registers, decode, stall logic and the counter.

Test Plan:
- Add-and-store, defaults, valid=ready=1. Sequence: @2, D=A (0xEC10), @3, D=D+A (0xE090), @0, M=D (0xE308).
  - Required: on M=D, writeM=1, outM=5, addressM=0.
  - retired=6 after the sixth edge; pc=6.
- Conditional jump. Sequence: @7, D=0 (0xEA90), @7, D;JEQ (0xE302).
  - Required: pc=7 after the JEQ edge.
  - With D=1, the same JEQ gives pc=pc+1.
- instr_valid low for 3 cycles mid-program: pc, A, D and retired are unchanged, writeM=0. Execution resumes identically afterwards.
- M=D with mem_ready low for 2 cycles: writeM=1 and outM held for all 3 cycles.
  - pc advances and retired increments only in the ready cycle.
  - D=M (0xFC10) stalls the same way and loads inM=0x1234 only on ready.
- Reset mid-stall: drive reset=0 asynchronously between edges.
  - Required: pc=0, retired=0, writeM=0 immediately.
  - After release, the first instruction executes from pc=0.
- DATA_W=32, ADDR_W=20, instruction 0x7FFF_FFFF (A-instruction).
  - Required: A=0x7FFF_FFFF, addressM=0xFFFFF.
  - D=D+A with D=1 gives outM=0x8000_0000 and ng=1, so jlt is taken.
